// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned MD_XLEN = 32;

   // M-extension funct3 encodings
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_CALC  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } muldiv_state_e;

   // Most negative two's-complement value of a w-bit word (w <= 64)
   function automatic logic [63:0] md_int_min(input int unsigned w);
      return 64'(1) << (w - 1);
   endfunction

   // All-ones pattern of a w-bit word (w <= 64)
   function automatic logic [63:0] md_all_ones(input int unsigned w);
      if (w >= 64) return '1;
      return (64'(1) << w) - 64'(1);
   endfunction

   // div/divu/rem/remu share funct3[2]
   function automatic logic md_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   // rs1 is interpreted as signed for mulh, mulhsu, div, rem
   function automatic logic md_rs1_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is interpreted as signed for mulh, div, rem (mulhsu takes it unsigned)
   function automatic logic md_rs2_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*XLEN accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic                is_div_i,
   input  logic [2*XLEN-1:0]   acc_i,
   input  logic [XLEN-1:0]     opnd_i,
   output logic [2*XLEN-1:0]   acc_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_shift;
   logic [XLEN:0] diff;

   // Multiply: {hi,lo} with multiplier in lo, add multiplicand to hi when lo[0]
   // is set, then shift right. Divide: {rem,quo}, shift left, subtract divisor
   // when the shifted remainder does not borrow.
   always_comb begin
      sum       = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
      rem_shift = acc_i[2*XLEN-1:XLEN-1];
      diff      = rem_shift - {1'b0, opnd_i};
      acc_o     = acc_i;
      if (is_div_i) begin
         if (!diff[XLEN]) begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         end else begin
            acc_o = {rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         end
      end else if (acc_i[0]) begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end else begin
         acc_o = {1'b0, acc_i[2*XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes in
// PREP, iterated UNROLL steps per CALC cycle, and sign-corrected in FIXUP.
// Division by zero and the signed-overflow case bypass CALC entirely.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN   = MD_XLEN,
   parameter int unsigned UNROLL = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [2:0]        i_op,
   input  logic [XLEN-1:0]   i_rs1,
   input  logic [XLEN-1:0]   i_rs2,
   input  logic              i_kill,
   output logic              o_ready,
   output logic              o_stall,
   output logic              o_valid,
   output logic [XLEN-1:0]   o_result
);

   localparam int unsigned N     = XLEN / UNROLL;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [XLEN-1:0] INT_MIN  = XLEN'(md_int_min(XLEN));
   localparam logic [XLEN-1:0] ALL_ONES = XLEN'(md_all_ones(XLEN));

   muldiv_state_e         state_q;
   muldiv_op_e            op_q;
   logic [XLEN-1:0]       rs1_q;
   logic [XLEN-1:0]       rs2_q;
   logic [2*XLEN-1:0]     acc_q;
   logic [XLEN-1:0]       opnd_q;
   logic                  neg_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  valid_q;
   logic [XLEN-1:0]       result_q;

   logic                  s1_d;
   logic                  s2_d;
   logic [XLEN-1:0]       mag1_d;
   logic [XLEN-1:0]       mag2_d;
   logic                  neg_d;
   logic                  early_d;
   logic [XLEN-1:0]       early_res_d;
   logic [2*XLEN-1:0]     acc_d;
   logic [2*XLEN-1:0]     prod_d;
   logic [XLEN-1:0]       quo_d;
   logic [XLEN-1:0]       rem_d;
   logic [XLEN-1:0]       fix_res_d;
   logic                  is_div;

   assign is_div = md_is_div(op_q);

   // PREP: operand magnitudes, result sign and early-out detection
   always_comb begin
      s1_d        = md_rs1_signed(op_q) & rs1_q[XLEN-1];
      s2_d        = md_rs2_signed(op_q) & rs2_q[XLEN-1];
      mag1_d      = s1_d ? (~rs1_q + 1'b1) : rs1_q;
      mag2_d      = s2_d ? (~rs2_q + 1'b1) : rs2_q;
      // remainder takes the dividend's sign; everything else the xor
      neg_d       = (op_q == OP_REM) ? s1_d : (s1_d ^ s2_d);
      early_d     = 1'b0;
      early_res_d = '0;
      if (is_div) begin
         if (rs2_q == '0) begin
            early_d     = 1'b1;
            early_res_d = op_q[1] ? rs1_q : ALL_ONES;
         end else if (md_rs1_signed(op_q) && (rs1_q == INT_MIN) && (rs2_q == ALL_ONES)) begin
            early_d     = 1'b1;
            early_res_d = op_q[1] ? '0 : INT_MIN;
         end
      end
   end

   // CALC: chain of UNROLL radix-2 steps
   logic [2*XLEN-1:0] chain [UNROLL+1];
   assign chain[0] = acc_q;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      muldiv_step #(
         .XLEN (XLEN)
      ) u_step (
         .is_div_i (is_div),
         .acc_i    (chain[g]),
         .opnd_i   (opnd_q),
         .acc_o    (chain[g+1])
      );
   end

   assign acc_d = chain[UNROLL];

   // FIXUP: sign correction and half/quotient/remainder selection
   always_comb begin
      prod_d = neg_q ? (~acc_q + 1'b1) : acc_q;
      quo_d  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_d  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                        fix_res_d = prod_d[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_d = prod_d[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               fix_res_d = quo_d;
         default:                       fix_res_d = rem_d;
      endcase
   end

   // Control FSM with registered valid/result; kill and reset abort to IDLE
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         valid_q  <= 1'b0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         if (i_kill) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (i_start) begin
                     op_q    <= muldiv_op_e'(i_op);
                     rs1_q   <= i_rs1;
                     rs2_q   <= i_rs2;
                     state_q <= ST_PREP;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_PREP: begin
                  if (early_d) begin
                     result_q <= early_res_d;
                     valid_q  <= 1'b1;
                     state_q  <= ST_DONE;
                  end else begin
                     acc_q   <= {{XLEN{1'b0}}, mag1_d};
                     opnd_q  <= mag2_d;
                     neg_q   <= neg_d;
                     cnt_q   <= CNT_W'(N - 1);
                     state_q <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  acc_q <= acc_d;
                  if (cnt_q == '0) begin
                     state_q <= ST_FIXUP;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               ST_FIXUP: begin
                  result_q <= fix_res_d;
                  valid_q  <= 1'b1;
                  state_q  <= ST_DONE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign o_stall  = (i_start & ~o_ready) ||
                     (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIXUP);
   assign o_valid  = valid_q;
   assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latencies, kill/reset, back-to-back,
// and a second instance built with UNROLL=4.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   // Latency counted in rising edges, the accepting edge being edge 1 and the
   // last one being the edge that captures o_valid.
   localparam int LAT_N   = 32 / 1 + 3;
   localparam int LAT_N4  = 32 / 4 + 3;
   localparam int LAT_EO  = 2;
   // An accept in DONE replays PREP, N CALC cycles, FIXUP and DONE.
   localparam int LAT_B2B = 32 / 1 + 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, kill;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic        ready, stall, valid;
   logic [31:0] result;

   logic        start4, kill4;
   logic [2:0]  op4;
   logic [31:0] rs1_4, rs2_4;
   logic        ready4, stall4, valid4;
   logic [31:0] result4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(32), .UNROLL(1)) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_start  (start),
      .i_op     (op),
      .i_rs1    (rs1),
      .i_rs2    (rs2),
      .i_kill   (kill),
      .o_ready  (ready),
      .o_stall  (stall),
      .o_valid  (valid),
      .o_result (result)
   );

   muldiv_seq #(.XLEN(32), .UNROLL(4)) dut4 (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_start  (start4),
      .i_op     (op4),
      .i_rs1    (rs1_4),
      .i_rs2    (rs2_4),
      .i_kill   (kill4),
      .o_ready  (ready4),
      .o_stall  (stall4),
      .o_valid  (valid4),
      .o_result (result4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request and wait (bounded) for o_valid; reports edge count,
   // result and whether o_stall stayed high until o_valid.
   task automatic run_op(input bit u4, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] res,
                         output bit stall_ok);
      logic v, s;
      if (u4) begin
         op4 = o; rs1_4 = a; rs2_4 = b; start4 = 1'b1;
      end else begin
         op = o; rs1 = a; rs2 = b; start = 1'b1;
      end
      tick;
      start    = 1'b0;
      start4   = 1'b0;
      lat      = 1;
      stall_ok = 1'b1;
      v = u4 ? valid4 : valid;
      while (!v && lat < 200) begin
         s = u4 ? stall4 : stall;
         if (!s) stall_ok = 1'b0;
         tick;
         lat++;
         v = u4 ? valid4 : valid;
      end
      res = u4 ? result4 : result;
   endtask

   task automatic do_vec(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int explat);
      int lat;
      logic [31:0] res;
      bit sok;
      run_op(1'b0, o, a, b, lat, res, sok);
      check({tag, "_res"}, res, exp);
      check({tag, "_lat"}, 32'(lat), 32'(explat));
      check({tag, "_stall"}, 32'(sok), 32'd1);
      tick;
      check({tag, "_pulse"}, 32'(valid), 32'd0);
   endtask

   initial begin
      int lat;
      logic [31:0] res;
      bit sok;
      bit saw;

      rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      start4 = 1'b0; kill4 = 1'b0; op4 = '0; rs1_4 = '0; rs2_4 = '0;
      tick;
      tick;
      check("rst_valid",  32'(valid),  32'd0);
      check("rst_result", result,      32'd0);
      check("rst_ready",  32'(ready),  32'd1);
      check("rst_stall",  32'(stall),  32'd0);
      rst = 1'b0;
      tick;
      check("post_rst_ready", 32'(ready), 32'd1);

      do_vec("mul",      OP_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, LAT_N);
      do_vec("mulh",     OP_MULH,   32'h80000000,  32'h80000000, 32'h40000000, LAT_N);
      do_vec("mulhu",    OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, LAT_N);
      do_vec("mulhsu",   OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, LAT_N);
      do_vec("div",      OP_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, LAT_N);
      do_vec("rem",      OP_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, LAT_N);
      do_vec("divu",     OP_DIVU,   32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, LAT_N);
      do_vec("remu",     OP_REMU,   32'd7,         32'd3,        32'd1,        LAT_N);
      do_vec("div_ovf",  OP_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, LAT_EO);
      do_vec("rem_ovf",  OP_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        LAT_EO);
      do_vec("div_z",    OP_DIV,    32'd5,         32'd0,        32'hFFFFFFFF, LAT_EO);
      do_vec("remu_z",   OP_REMU,   32'd5,         32'd0,        32'd5,        LAT_EO);

      // kill during the 10th CALC cycle; previous result (5) must survive
      op = OP_MUL; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick;
      kill = 1'b1;
      tick;
      kill = 1'b0;
      check("kill_valid",  32'(valid), 32'd0);
      check("kill_ready",  32'(ready), 32'd1);
      check("kill_result", result,     32'd5);
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (valid) saw = 1'b1;
      end
      check("kill_no_valid", 32'(saw), 32'd0);

      // kill together with start in IDLE: request dropped
      op = OP_MUL; rs1 = 32'd7; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
      check("killstart_stall", 32'(stall), 32'd0);
      tick;
      start = 1'b0; kill = 1'b0;
      check("killstart_ready", 32'(ready), 32'd1);
      check("killstart_nostall", 32'(stall), 32'd0);
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (valid) saw = 1'b1;
      end
      check("killstart_no_valid", 32'(saw), 32'd0);
      check("killstart_result", result, 32'd5);

      // reset in the middle of CALC
      op = OP_MUL; rs1 = 32'd7; rs2 = 32'd3; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick;
      check("midrst_busy", 32'(stall), 32'd1);
      rst = 1'b1;
      tick;
      check("midrst_valid",  32'(valid), 32'd0);
      check("midrst_result", result,     32'd0);
      check("midrst_ready",  32'(ready), 32'd1);
      check("midrst_stall",  32'(stall), 32'd0);
      rst = 1'b0;
      tick;
      check("midrst_post_ready",  32'(ready), 32'd1);
      check("midrst_post_result", result,     32'd0);

      // back-to-back: second request issued in the DONE cycle of the first
      run_op(1'b0, OP_MUL, 32'd7, 32'hFFFFFFFD, lat, res, sok);
      check("b2b_first_res",   res,        32'hFFFFFFEB);
      check("b2b_done_ready",  32'(ready), 32'd1);
      run_op(1'b0, OP_DIVU, 32'hFFFFFFF9, 32'd2, lat, res, sok);
      check("b2b_second_res",  res,        32'h7FFFFFFC);
      check("b2b_second_lat",  32'(lat),   32'(LAT_B2B));
      tick;

      // UNROLL=4 instance, same multiply
      run_op(1'b1, OP_MUL, 32'd7, 32'hFFFFFFFD, lat, res, sok);
      check("u4_mul_res",   res,       32'hFFFFFFEB);
      check("u4_mul_lat",   32'(lat),  32'(LAT_N4));
      check("u4_mul_stall", 32'(sok),  32'd1);
      tick;
      check("u4_mul_pulse", 32'(valid4), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
